uart_ttl_recv: RTL and testbench

Serial receiver for the UART path; the RX counterpart to `uart_ttl_send`. It takes the asynchronous TTL line and synchronizes it into `clk`. It finds the start bit and samples 8 data bits at mid-bit, LSB first, then checks the stop bit. Each good byte is presented on a one-cycle strobe to the downstream consumer (command decoder / FIFO). Format is fixed 8N1. The block has its own bit-period counter and needs no external baud tick.

---
 rtl/uart_ttl_recv.sv | 180 ++++++++++++++++++
 tb/tb_uart_ttl_recv.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_ttl_recv.sv
// ---------------------------------------------------------------------------
// uart_ttl_recv
//
// Fixed-format 8N1 UART receiver. The asynchronous TTL line is brought into
// the clk domain through a two-flop synchronizer. A start bit is qualified at
// mid-bit, eight data bits are sampled at mid-bit (LSB first), and the stop
// bit is checked. The block times bit periods itself and needs no external
// baud tick.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (minimum 8)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   serial_recv  in   asynchronous UART line, idles high
//   recv_data    out  [7:0] last good byte, held until the next good frame
//   recv_valid   out  one-cycle strobe: recv_data was updated this cycle
//   frame_error  out  one-cycle strobe: stop bit was sampled low
//   busy         out  high whenever the receiver is not idle
//
// Output handshake: recv_valid is a single-cycle strobe with no ready/back-
// pressure. A consumer that misses the strobe loses the event, although
// recv_data keeps the byte until the next good frame. recv_valid and
// frame_error are mutually exclusive.
// ---------------------------------------------------------------------------
module uart_ttl_recv #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_recv,
    output logic [7:0] recv_data,
    output logic       recv_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          sync_1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;

    logic          half_done;
    logic          bit_done;
    logic          valid_set;
    logic          ferr_set;

    assign half_done = (cnt == CNT_HALF);
    assign bit_done  = (cnt == CNT_FULL);

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a falling start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= serial_recv;
            rx_s   <= sync_1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                // A line that is high again at mid-start-bit was a glitch.
                if (half_done) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done && (idx == 3'd7)) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start bit be seen.
                if (bit_done) begin
                    state_next = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break is one error.
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy      = (state != S_IDLE);
        valid_set = 1'b0;
        ferr_set  = 1'b0;
        if (state == S_STOP && bit_done) begin
            valid_set = rx_s;
            ferr_set  = !rx_s;
        end
    end

    // Datapath: bit timer, bit index, shift register and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 3'd0;
            sh          <= 8'h00;
            recv_data   <= 8'h00;
            recv_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            recv_valid  <= valid_set;
            frame_error <= ferr_set;
            if (valid_set) begin
                recv_data <= sh;
            end

            case (state)
                S_START: begin
                    idx <= 3'd0;
                    cnt <= half_done ? '0 : cnt + 1'b1;
                end
                S_DATA: begin
                    if (bit_done) begin
                        sh[idx] <= rx_s;
                        cnt     <= '0;
                        if (idx != 3'd7) begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    cnt <= bit_done ? '0 : cnt + 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ttl_recv.sv
// ---------------------------------------------------------------------------
// tb_uart_ttl_recv
//
// Directed bench for uart_ttl_recv at 16 clocks per bit. Frames are driven
// bit by bit on the falling clock edge; every good byte is pushed onto an
// expected queue when driven and popped when recv_valid strobes.
// ---------------------------------------------------------------------------
module tb_uart_ttl_recv;

    localparam int CLKS = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_recv = 1'b1;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       frame_error;
    logic       busy;

    always #5 clk = ~clk;

    uart_ttl_recv #(.CLKS_PER_BIT(CLKS)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_recv (serial_recv),
        .recv_data   (recv_data),
        .recv_valid  (recv_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    // ---------------- bookkeeping ----------------
    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         fall_cyc  = 0;
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         snap;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v);
        serial_recv = v;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic idle(input int n);
        serial_recv = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (recv_valid && frame_error) both_cnt++;
            if (recv_valid) begin
                int lat;
                valid_cnt++;
                lat = cyc - fall_cyc - 1;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_valid observed=%0h expected=none", recv_data);
                end
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("recv_data", {24'd0, recv_data}, {24'd0, e});
                    last_good = e;
                end
                checks++;
                assert (lat >= 149 && lat <= 155) else begin
                    failures++;
                    $error("FAIL latency observed=%0d expected=149..155", lat);
                end
            end
            if (frame_error) begin
                ferr_cnt++;
                check("data_hold_on_ferr", {24'd0, recv_data}, {24'd0, last_good});
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset
        rst = 1'b1;
        serial_recv = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_recv_data", {24'd0, recv_data}, 32'h00);
        check("rst_recv_valid", {31'd0, recv_valid}, 32'd0);
        check("rst_frame_error", {31'd0, frame_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        idle(8);

        // Single byte
        snap = valid_cnt;
        send_good(8'hA5);
        idle(8);
        check("single_pulse_count", snap + 1, valid_cnt);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back
        snap = valid_cnt;
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h55);
        idle(8);
        check("b2b_pulse_count", valid_cnt, snap + 3);
        check("b2b_no_ferr", ferr_cnt, 0);

        // Glitch
        snap = valid_cnt;
        serial_recv = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        serial_recv = 1'b1;
        for (int i = 0; i < 12 && busy; i++) @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        idle(CLKS * 12);
        check("glitch_no_valid", valid_cnt, snap);

        // Frame error then recovery
        snap = valid_cnt;
        send_frame(8'h3C, 1'b0);
        serial_recv = 1'b0;
        repeat (40) @(negedge clk);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_valid", valid_cnt, snap);
        check("ferr_busy_in_break", {31'd0, busy}, 32'd1);
        idle(CLKS);
        check("ferr_data_hold", {24'd0, recv_data}, 32'h55);
        send_good(8'h81);
        idle(8);
        check("after_ferr_valid", valid_cnt, snap + 1);

        // Mid-frame reset during bit 4 of C3
        snap = valid_cnt;
        serial_recv = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
        serial_recv = 1'b1;   // bit 4 of C3 is 0; reset lands mid-bit
        serial_recv = 1'b0;
        repeat (CLKS / 2) @(negedge clk);
        rst = 1'b1;
        serial_recv = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        check("mid_rst_data", {24'd0, recv_data}, 32'h00);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        idle(CLKS * 10);
        check("mid_rst_no_valid", valid_cnt, snap);
        send_good(8'h7E);
        idle(8);
        check("after_rst_valid", valid_cnt, snap + 1);

        // Drain and summarise
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("total_valid", valid_cnt, 6);
        check("total_ferr", ferr_cnt, 1);
        check("never_both", both_cnt, 0);
        check("final_data", {24'd0, recv_data}, 32'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
